// File: rtl/dna_ctrlport_pkg.sv
// Shared definitions for the device-DNA CtrlPort register block: response
// status codes, unload FSM states, per-device DNA source widths and the
// fixed simulation DNA values.
package dna_ctrlport_pkg;

  // CtrlPort response status codes
  localparam logic [1:0] CTRL_STS_OKAY   = 2'b00;
  localparam logic [1:0] CTRL_STS_CMDERR = 2'b01;

  // Width of the serial DNA source for each supported device family
  localparam int HW_BITS_ULTRASCALE = 96;
  localparam int HW_BITS_7SERIES    = 57;

  // Widest source; used as the common carrier width for DNA constants
  localparam int HW_BITS_MAX = 96;

  // Fixed IDs returned by the behavioural source in simulation
  localparam logic [95:0] DNA_SIM_ULTRASCALE = 96'h012F1110_C0D111A0_11C0FFEE;
  localparam logic [56:0] DNA_SIM_7SERIES    = 57'h0D1_11A0_C0DE_00FF;

  // Unload FSM states
  typedef enum logic [1:0] {
    ST_LOAD  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2
  } unload_state_e;

  // Number of DNA bits the selected device family provides; 0 marks an
  // unsupported family so that the instantiating module can refuse to build.
  function automatic int dna_hw_bits(input string dev);
    if (dev == "ULTRASCALE") begin
      return HW_BITS_ULTRASCALE;
    end else if (dev == "7SERIES") begin
      return HW_BITS_7SERIES;
    end else begin
      return 0;
    end
  endfunction

  // Simulation DNA for the selected family, right-aligned in HW_BITS_MAX bits
  function automatic logic [HW_BITS_MAX-1:0] dna_sim_value(input string dev);
    if (dev == "7SERIES") begin
      return HW_BITS_MAX'(DNA_SIM_7SERIES);
    end else begin
      return DNA_SIM_ULTRASCALE;
    end
  endfunction

endpackage

// File: rtl/dna_source.sv
// Serial device-DNA source. This is the behavioural model with the same
// read/shift/dout interface as the vendor DNA primitive: 'read' parallel-loads
// the ID, each 'shift' moves it one bit toward dout, LSB first. A synthesis
// build swaps this body for the DNA_PORT / DNA_PORTE2 primitive wrapper.
module dna_source
  import dna_ctrlport_pkg::*;
#(
  parameter string DEVICE_TYPE = "ULTRASCALE"
) (
  input  logic clk,
  input  logic read,
  input  logic shift,
  output logic dout
);

  localparam int HW_BITS = dna_hw_bits(DEVICE_TYPE);
  localparam logic [HW_BITS_MAX-1:0] DNA_FULL = dna_sim_value(DEVICE_TYPE);
  localparam logic [HW_BITS-1:0] DNA_VALUE = DNA_FULL[HW_BITS-1:0];

  // Unsupported family names must fail at elaboration, not silently build
  if (HW_BITS == 0) begin : g_bad_device
    $error("dna_source: unsupported DEVICE_TYPE");
  end

  logic [HW_BITS-1:0] r_sr;

  // Like the primitive, the shift register has no reset; 'read' defines it
  always_ff @(posedge clk) begin
    if (read) begin
      r_sr <= DNA_VALUE;
    end else if (shift) begin
      r_sr <= {1'b0, r_sr[HW_BITS-1:1]};
    end
  end

  assign dout = r_sr[0];

endmodule

// File: rtl/dna_ctrlport_regs.sv
// Read-only CtrlPort slave exposing the device DNA as consecutive 32-bit
// words. After reset the DNA is unloaded serially from dna_source into a
// shadow register; reads before the unload finishes are acked with CMDERR.
//
// Handshake: a request is a single-cycle s_ctrlport_req_rd strobe with its
// address valid in the same cycle; there is no backpressure. Every request
// that hits this block's window gets exactly one s_ctrlport_resp_ack pulse in
// the following cycle, with status/data valid in that ack cycle only (data is
// zero otherwise, status holds until the next ack). Misses are never acked.
module dna_ctrlport_regs
  import dna_ctrlport_pkg::*;
#(
  parameter int    BASE_ADDR   = 0,
  parameter int    DNA_WIDTH   = 96,
  parameter string DEVICE_TYPE = "ULTRASCALE"
) (
  input  logic        ctrlport_clk,
  input  logic        reset_n,
  input  logic        s_ctrlport_req_rd,
  input  logic [19:0] s_ctrlport_req_addr,
  output logic        s_ctrlport_resp_ack,
  output logic [1:0]  s_ctrlport_resp_status,
  output logic [31:0] s_ctrlport_resp_data
);

  localparam int HW_BITS   = dna_hw_bits(DEVICE_TYPE);
  localparam int NUM_WORDS = (DNA_WIDTH + 31) / 32;
  localparam int PAD_W     = NUM_WORDS * 32;
  localparam int CNT_W     = $clog2(HW_BITS + 1);

  localparam logic [20:0] BASE_L = 21'(BASE_ADDR);
  localparam logic [20:0] SPAN_L = 21'(4 * NUM_WORDS);

  if (HW_BITS == 0) begin : g_bad_device
    $error("dna_ctrlport_regs: unsupported DEVICE_TYPE");
  end
  if ((BASE_ADDR % 4) != 0) begin : g_bad_base
    $error("dna_ctrlport_regs: BASE_ADDR must be 4-byte aligned");
  end

  // ---------------------------------------------------------------------
  // DNA source and unload FSM
  // ---------------------------------------------------------------------
  unload_state_e      r_state;
  logic               r_src_read;
  logic               r_src_shift;
  logic [CNT_W-1:0]   r_bit_cnt;
  logic [HW_BITS-1:0] r_dna;
  logic               r_ready;
  logic               w_src_dout;

  dna_source #(
    .DEVICE_TYPE (DEVICE_TYPE)
  ) u_dna_source (
    .clk   (ctrlport_clk),
    .read  (r_src_read),
    .shift (r_src_shift),
    .dout  (w_src_dout)
  );

  // Unload FSM: LOAD latches the ID in the source, SHIFT collects HW_BITS
  // bits LSB first into a right-shifting register, DONE holds until reset.
  // r_src_read is already high out of reset so the LOAD cycle latches.
  always_ff @(posedge ctrlport_clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state     <= ST_LOAD;
      r_src_read  <= 1'b1;
      r_src_shift <= 1'b0;
      r_bit_cnt   <= '0;
      r_dna       <= '0;
      r_ready     <= 1'b0;
    end else begin
      case (r_state)
        ST_LOAD: begin
          r_src_read  <= 1'b0;
          r_src_shift <= 1'b1;
          r_bit_cnt   <= '0;
          r_state     <= ST_SHIFT;
        end
        ST_SHIFT: begin
          r_dna <= {w_src_dout, r_dna[HW_BITS-1:1]};
          if (r_bit_cnt == CNT_W'(HW_BITS - 1)) begin
            r_src_shift <= 1'b0;
            r_ready     <= 1'b1;
            r_state     <= ST_DONE;
          end else begin
            r_bit_cnt <= r_bit_cnt + 1'b1;
          end
        end
        ST_DONE: begin
          r_src_read  <= 1'b0;
          r_src_shift <= 1'b0;
        end
        default: begin
          r_src_read  <= 1'b1;
          r_src_shift <= 1'b0;
          r_state     <= ST_LOAD;
        end
      endcase
    end
  end

  // ---------------------------------------------------------------------
  // Shadow register view and address decode
  // ---------------------------------------------------------------------
  // Width casts zero-extend the HW bits into the exposed register, or drop
  // the upper HW bits when the exposed register is narrower.
  logic [DNA_WIDTH-1:0] w_shadow;
  logic [PAD_W-1:0]     w_padded;
  logic [20:0]          w_offset;
  logic [17:0]          w_idx;
  logic [1:0]           w_unused_addr_lsbs;
  logic                 w_hit;
  logic                 w_rd_hit;
  logic [31:0]          w_rd_word;

  assign w_shadow = DNA_WIDTH'(r_dna);
  assign w_padded = PAD_W'(w_shadow);

  // Addresses below the base wrap the 21-bit difference, setting bit 20
  assign w_offset           = {1'b0, s_ctrlport_req_addr} - BASE_L;
  assign w_hit              = !w_offset[20] && (w_offset < SPAN_L);
  assign w_idx              = w_offset[19:2];
  assign w_unused_addr_lsbs = w_offset[1:0];
  assign w_rd_hit           = s_ctrlport_req_rd && w_hit;

  // Select the addressed 32-bit word of the padded shadow register
  always_comb begin
    w_rd_word = '0;
    for (int i = 0; i < NUM_WORDS; i++) begin
      if (w_idx == 18'(i)) begin
        w_rd_word = w_padded[i*32 +: 32];
      end
    end
  end

  // ---------------------------------------------------------------------
  // Registered read response
  // ---------------------------------------------------------------------
  logic        r_ack;
  logic [1:0]  r_status;
  logic [31:0] r_data;

  // One-cycle ack per hit; data only during ack, status sticky between acks
  always_ff @(posedge ctrlport_clk or negedge reset_n) begin
    if (!reset_n) begin
      r_ack    <= 1'b0;
      r_status <= CTRL_STS_OKAY;
      r_data   <= '0;
    end else begin
      r_ack <= w_rd_hit;
      if (w_rd_hit) begin
        r_status <= r_ready ? CTRL_STS_OKAY : CTRL_STS_CMDERR;
        r_data   <= r_ready ? w_rd_word : 32'h0;
      end else begin
        r_data <= '0;
      end
    end
  end

  assign s_ctrlport_resp_ack    = r_ack;
  assign s_ctrlport_resp_status = r_status;
  assign s_ctrlport_resp_data   = r_data;

endmodule

// File: tb/tb_dna_ctrlport_regs.sv
// Directed bench for dna_ctrlport_regs: two instances (UltraScale at base 0,
// 7-series at base 32) share one CtrlPort request bus.
module tb_dna_ctrlport_regs;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset_n;
  logic        req_rd;
  logic [19:0] req_addr;

  logic        a_ack, b_ack;
  logic [1:0]  a_sts, b_sts;
  logic [31:0] a_data, b_data;

  dna_ctrlport_regs #(
    .BASE_ADDR   (0),
    .DNA_WIDTH   (128),
    .DEVICE_TYPE ("ULTRASCALE")
  ) u_a (
    .ctrlport_clk           (clk),
    .reset_n                (reset_n),
    .s_ctrlport_req_rd      (req_rd),
    .s_ctrlport_req_addr    (req_addr),
    .s_ctrlport_resp_ack    (a_ack),
    .s_ctrlport_resp_status (a_sts),
    .s_ctrlport_resp_data   (a_data)
  );

  dna_ctrlport_regs #(
    .BASE_ADDR   (32),
    .DNA_WIDTH   (57),
    .DEVICE_TYPE ("7SERIES")
  ) u_b (
    .ctrlport_clk           (clk),
    .reset_n                (reset_n),
    .s_ctrlport_req_rd      (req_rd),
    .s_ctrlport_req_addr    (req_addr),
    .s_ctrlport_resp_ack    (b_ack),
    .s_ctrlport_resp_status (b_sts),
    .s_ctrlport_resp_data   (b_data)
  );

  // ---------------- scoreboard ----------------
  int n_tests = 0;
  int n_fail  = 0;
  logic [31:0] exp_q[$];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // ---------------- driver tasks ----------------
  // Called just after a falling edge; drives a one-cycle read and returns
  // on the next falling edge, where the registered response is visible.
  task automatic rd(input logic [19:0] addr);
    req_rd   = 1'b1;
    req_addr = addr;
    @(negedge clk);
    req_rd   = 1'b0;
    req_addr = '0;
  endtask

  // One-cycle reset pulse; checks the async clear while reset is low
  task automatic pulse_reset(input string tag);
    reset_n = 1'b0;
    #1;
    check({tag, "_a_sts_in_reset"}, 32'(a_sts), 32'h0);
    check({tag, "_a_ack_in_reset"}, 32'(a_ack), 32'h0);
    @(negedge clk);
    reset_n = 1'b1;
  endtask

  // Directed A vectors: address and hand-computed word
  logic [19:0] a_vec_addr[4] = '{20'd0, 20'd4, 20'd8, 20'd12};
  logic [31:0] a_vec_data[4] = '{32'h11C0FFEE, 32'hC0D111A0, 32'h012F1110, 32'h00000000};

  int polls;

  initial begin
    reset_n  = 1'b0;
    req_rd   = 1'b0;
    req_addr = '0;

    // Reset state
    @(negedge clk);
    check("rst_a_ack",  32'(a_ack), 32'h0);
    check("rst_a_sts",  32'(a_sts), 32'h0);
    check("rst_a_data", a_data,     32'h0);
    check("rst_b_ack",  32'(b_ack), 32'h0);
    check("rst_b_sts",  32'(b_sts), 32'h0);
    check("rst_b_data", b_data,     32'h0);
    reset_n = 1'b1;
    @(negedge clk);

    // Early read: DNA not loaded yet -> CMDERR with zero data, still acked
    pulse_reset("early");
    repeat (12) @(negedge clk);
    rd(20'd0);
    check("early_a_ack",  32'(a_ack), 32'h1);
    check("early_a_sts",  32'(a_sts), 32'h1);
    check("early_a_data", a_data,     32'h0);
    check("early_b_ack",  32'(b_ack), 32'h0);
    @(negedge clk);
    check("early_ack_pulse", 32'(a_ack), 32'h0);
    check("early_sts_hold",  32'(a_sts), 32'h1);

    // Reset clears the sticky CMDERR status and restarts the unload
    pulse_reset("reload1");
    check("reload1_sts_after", 32'(a_sts), 32'h0);
    repeat (110) @(negedge clk);

    // A words after load, B silent
    for (int i = 0; i < 4; i++) begin
      exp_q.push_back(a_vec_data[i]);
      check($sformatf("a_idle_before_%0d", i), 32'(a_ack), 32'h0);
      rd(a_vec_addr[i]);
      check($sformatf("a_ack_%0d", i), 32'(a_ack), 32'h1);
      check($sformatf("a_sts_%0d", i), 32'(a_sts), 32'h0);
      check($sformatf("a_data_%0d", i), a_data, exp_q.pop_front());
      check($sformatf("b_noack_%0d", i), 32'(b_ack), 32'h0);
      @(negedge clk);
      check($sformatf("a_data_idle_%0d", i), a_data, 32'h0);
    end

    // Reload: poll until OKAY
    pulse_reset("reload2");
    polls = 0;
    do begin
      rd(20'd0);
      polls++;
    end while (!(a_ack && a_sts == 2'b00) && polls < 200);
    check("reload_in_time", 32'(polls < 200), 32'h1);
    check("reload_data",    a_data, 32'h11C0FFEE);
    @(negedge clk);
    repeat (5) @(negedge clk);

    // B reads, A silent
    rd(20'd32);
    check("b32_ack",  32'(b_ack), 32'h1);
    check("b32_sts",  32'(b_sts), 32'h0);
    check("b32_data", b_data,     32'hC0DE00FF);
    check("b32_a_noack", 32'(a_ack), 32'h0);
    @(negedge clk);
    rd(20'd36);
    check("b36_ack",  32'(b_ack), 32'h1);
    check("b36_sts",  32'(b_sts), 32'h0);
    check("b36_data", b_data,     32'h00D111A0);
    check("b36_a_noack", 32'(a_ack), 32'h0);
    @(negedge clk);

    // Miss beyond both windows
    rd(20'd40);
    check("miss40_a_ack", 32'(a_ack), 32'h0);
    check("miss40_b_ack", 32'(b_ack), 32'h0);
    check("miss40_b_data", b_data, 32'h0);
    @(negedge clk);

    // Byte offsets within a word are ignored
    rd(20'd1);
    check("addr1_ack",  32'(a_ack), 32'h1);
    check("addr1_data", a_data, 32'h11C0FFEE);
    @(negedge clk);
    rd(20'd3);
    check("addr3_ack",  32'(a_ack), 32'h1);
    check("addr3_data", a_data, 32'h11C0FFEE);
    @(negedge clk);

    // Back-to-back reads: one ack per request, each one cycle later
    req_rd   = 1'b1;
    req_addr = 20'd0;
    @(negedge clk);
    check("b2b0_ack",  32'(a_ack), 32'h1);
    check("b2b0_data", a_data, 32'h11C0FFEE);
    req_addr = 20'd4;
    @(negedge clk);
    check("b2b1_ack",  32'(a_ack), 32'h1);
    check("b2b1_data", a_data, 32'hC0D111A0);
    req_addr = 20'd8;
    @(negedge clk);
    check("b2b2_ack",  32'(a_ack), 32'h1);
    check("b2b2_data", a_data, 32'h012F1110);
    req_rd   = 1'b0;
    req_addr = '0;
    @(negedge clk);
    check("b2b_end_ack",  32'(a_ack), 32'h0);
    check("b2b_end_data", a_data, 32'h0);

    // Reset in the middle of a read drops the pending response
    req_rd   = 1'b1;
    req_addr = 20'd4;
    @(posedge clk);
    #1;
    req_rd  = 1'b0;
    reset_n = 1'b0;
    #1;
    check("midrd_ack_dropped", 32'(a_ack), 32'h0);
    check("midrd_data_idle",   a_data,     32'h0);
    @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    rd(20'd0);
    check("midrd_reload_sts", 32'(a_sts), 32'h1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  // Safety bound so the bench always terminates
  initial begin
    #200000;
    $display("FAIL timeout: simulation exceeded time bound");
    $fatal(1, "timeout");
  end

endmodule
